// File: rtl/me_pkg.sv
// ============================================================================
// Module      : me_pkg
// Description : Shared state encoding and geometry constants for the motion
//               estimation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package me_pkg;

    localparam int unsigned RMEM_MAX   = 256;
    localparam int unsigned SMEM_MAX   = 1024;
    localparam int unsigned BLK_DIM    = 16;
    localparam int unsigned WIN_STRIDE = 32;
    localparam int unsigned STREAM_LEN = 271;

    localparam int unsigned RADDR_W = $clog2(RMEM_MAX);
    localparam int unsigned SADDR_W = $clog2(SMEM_MAX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_COLLECT = 3'd3,
        ST_DONE    = 3'd4
    } me_state_t;

endpackage

`default_nettype wire

// File: rtl/me_best_tracker.sv
// ============================================================================
// Module      : me_best_tracker
// Description : Keeps the smallest candidate distance and its displacement;
//               strict-less compare so ties keep the earlier candidate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module me_best_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_beat,
    input  logic [7:0] i_dist,
    input  logic [3:0] i_idx,
    input  logic [3:0] i_row,
    output logic [7:0] o_best_dist,
    output logic [3:0] o_motion_x,
    output logic [3:0] o_motion_y
);

    logic [7:0] r_best;
    logic [3:0] r_mx;
    logic [3:0] r_my;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= 8'hFF;
            r_mx   <= '0;
            r_my   <= '0;
        end else if (i_clear) begin
            r_best <= 8'hFF;
            r_mx   <= '0;
            r_my   <= '0;
        end else if (i_beat && (i_dist < r_best)) begin
            r_best <= i_dist;
            r_mx   <= i_idx;
            r_my   <= i_row;
        end
    end

    assign o_best_dist = r_best;
    assign o_motion_x  = r_mx;
    assign o_motion_y  = r_my;

endmodule

`default_nettype wire

// File: rtl/me_sequencer.sv
// ============================================================================
// Module      : me_sequencer
// Description : Full-search motion estimation sequencer: streams R/S addresses
//               row by row and collects 16 PE distances per candidate row.
//               Optional macro ME_SEQ_EARLY_EXIT_EN ends the search on a zero
//               distance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module me_sequencer
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [RADDR_W-1:0] AddressR,
    output logic [SADDR_W-1:0] AddressS1,
    output logic [SADDR_W-1:0] AddressS2,
    output logic               acc_clear,
    output logic               acc_en,
    input  logic               dist_valid,
    input  logic [7:0]         dist_in,
    input  logic [3:0]         dist_idx,
    output logic               busy,
    output logic               completed,
    output logic [7:0]         BestDist,
    output logic [3:0]         motionX,
    output logic [3:0]         motionY
);

    localparam logic [8:0] c_STREAM_LAST = 9'(STREAM_LEN - 1);
    localparam logic [3:0] c_LAST_IDX    = 4'(BLK_DIM - 1);

    me_state_t r_state;
    me_state_t w_next;
    logic [3:0] r_dy;
    logic [8:0] r_c;
    logic [3:0] r_beat;

    logic w_start_acc;
    logic w_beat;
    logic w_zero_hit;
    logic w_tail;
    logic [3:0] w_row;
    logic [4:0] w_win_row;
    logic [SADDR_W-1:0] w_s1;

`ifdef ME_SEQ_EARLY_EXIT_EN
    assign w_zero_hit = (dist_in == 8'd0);
`else
    assign w_zero_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_beat      = 1'b0;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;
        busy        = 1'b0;
        completed   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = ST_CLEAR;
                end
            end
            ST_DONE: begin
                completed = 1'b1;
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
                w_next    = ST_STREAM;
            end
            ST_STREAM: begin
                busy   = 1'b1;
                acc_en = 1'b1;
                if (r_c == c_STREAM_LAST) begin
                    w_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy = 1'b1;
                if (dist_valid) begin
                    w_beat = 1'b1;
                    if (w_zero_hit) begin
                        w_next = ST_DONE;
                    end else if (r_beat == c_LAST_IDX) begin
                        w_next = (r_dy == c_LAST_IDX) ? ST_DONE : ST_CLEAR;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dy   <= '0;
            r_c    <= '0;
            r_beat <= '0;
        end else begin
            if (w_start_acc) begin
                r_dy <= '0;
            end
            if (r_state == ST_CLEAR) begin
                r_c    <= '0;
                r_beat <= '0;
            end
            if (r_state == ST_STREAM) begin
                r_c <= r_c + 9'd1;
            end
            if (w_beat) begin
                r_beat <= r_beat + 4'd1;
                if ((r_beat == c_LAST_IDX) && (r_dy != c_LAST_IDX)) begin
                    r_dy <= r_dy + 4'd1;
                end
            end
        end
    end

    // Past the 256 pixels the tail stays on block row 15; its column (c-256)
    // equals c[3:0] over the tail range.
    assign w_tail    = (r_c >= 9'(RMEM_MAX));
    assign w_row     = w_tail ? c_LAST_IDX : r_c[7:4];
    assign w_win_row = {1'b0, r_dy} + {1'b0, w_row};
    assign w_s1      = SADDR_W'(w_win_row) * SADDR_W'(WIN_STRIDE) + SADDR_W'(r_c[3:0]);

    assign AddressR  = (r_state != ST_STREAM) ? '0 :
                       (w_tail ? RADDR_W'(RMEM_MAX - 1) : r_c[7:0]);
    assign AddressS1 = (r_state == ST_STREAM) ? w_s1 : '0;
    assign AddressS2 = (r_state == ST_STREAM) ? (w_s1 + SADDR_W'(BLK_DIM)) : '0;

    me_best_tracker u_best (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_start_acc),
        .i_beat      (w_beat),
        .i_dist      (dist_in),
        .i_idx       (dist_idx),
        .i_row       (r_dy),
        .o_best_dist (BestDist),
        .o_motion_x  (motionX),
        .o_motion_y  (motionY)
    );

endmodule

`default_nettype wire
